ttl_74165_sync: RTL and testbench

//  Synchronous model of the TTL 74165 8-bit parallel-in/serial-out shift register. It is the

---
 rtl/ttl_pkg.sv | 10 +
 rtl/ttl_pin_sync.sv | 41 ++++
 rtl/ttl_74165_sync.sv | 95 +++++++++
 tb/tb_ttl_74165_sync.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_pkg.sv
// Shared constants for the synchronous TTL chip models.
package ttl_pkg;

    localparam int unsigned TTL_SYNC_DEFAULT = 2;

    // Active-low control pins and clock pins rest high; data pins rest low.
    localparam logic TTL_CTRL_INACTIVE = 1'b1;
    localparam logic TTL_DATA_RESET    = 1'b0;

endpackage

// File: rtl/ttl_pin_sync.sv
// Parametric flop chain bringing chip pins into the system clock domain.
module ttl_pin_sync
    import ttl_pkg::*;
#(
    parameter int unsigned       STAGES    = TTL_SYNC_DEFAULT,
    parameter int unsigned       WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (STAGES == 0) begin : g_direct
            // Pass-through: clock and reset are intentionally unused here.
            logic unused_ok;
            assign unused_ok = ^{clk, reset};
            assign dout      = din;
        end else begin : g_chain
            logic [WIDTH-1:0] stage_q [STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int unsigned i = 0; i < STAGES; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else begin
                    stage_q[0] <= din;
                    for (int unsigned i = 1; i < STAGES; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign dout = stage_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/ttl_74165_sync.sv
// Synchronous 74165 parallel-in/serial-out shift register driven by an edge-detected pin clock.
module ttl_74165_sync
    import ttl_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = TTL_SYNC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SH_LD_n,
    input  logic             CLK,
    input  logic             CLK_INH,
    input  logic             SER,
    input  logic [WIDTH-1:0] P,
    output logic             Q_H,
    output logic             Q_H_n
);

    logic             sh_ld_n_s;
    logic             clk_s;
    logic             clk_inh_s;
    logic             ser_s;
    logic [WIDTH-1:0] p_s;

    logic             g;
    logic             g_prev;
    logic             rise;
    logic [WIDTH-1:0] sr;

    ttl_pin_sync #(
        .STAGES    (SYNC_STAGES),
        .WIDTH     (1),
        .RESET_VAL (TTL_CTRL_INACTIVE)
    ) u_sync_ld (
        .clk   (clk),
        .reset (reset),
        .din   (SH_LD_n),
        .dout  (sh_ld_n_s)
    );

    ttl_pin_sync #(
        .STAGES    (SYNC_STAGES),
        .WIDTH     (1),
        .RESET_VAL (TTL_CTRL_INACTIVE)
    ) u_sync_clk (
        .clk   (clk),
        .reset (reset),
        .din   (CLK),
        .dout  (clk_s)
    );

    ttl_pin_sync #(
        .STAGES    (SYNC_STAGES),
        .WIDTH     (1),
        .RESET_VAL (TTL_CTRL_INACTIVE)
    ) u_sync_inh (
        .clk   (clk),
        .reset (reset),
        .din   (CLK_INH),
        .dout  (clk_inh_s)
    );

    ttl_pin_sync #(
        .STAGES    (SYNC_STAGES),
        .WIDTH     (WIDTH + 1),
        .RESET_VAL ({(WIDTH + 1){TTL_DATA_RESET}})
    ) u_sync_data (
        .clk   (clk),
        .reset (reset),
        .din   ({SER, P}),
        .dout  ({ser_s, p_s})
    );

    // The chip clocks on the OR of CLK and CLK_INH, so inhibit edges count too.
    assign g    = clk_s | clk_inh_s;
    assign rise = g & ~g_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr     <= '0;
            g_prev <= 1'b1;
        end else begin
            g_prev <= g;
            if (!sh_ld_n_s) begin
                sr <= p_s;
            end else if (rise) begin
                sr <= {sr[WIDTH-2:0], ser_s};
            end
        end
    end

    assign Q_H   = sr[WIDTH-1];
    assign Q_H_n = ~sr[WIDTH-1];

endmodule

// File: tb/tb_ttl_74165_sync.sv
// Randomized and directed bench for ttl_74165_sync against a pin-level behavioural model.
module tb_ttl_74165_sync;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       sh_ld_n;
    logic       pclk;
    logic       inh;
    logic       ser;
    logic [7:0] p;
    logic [7:0] p_up;
    logic [7:0] p_dn;
    logic       q_h, q_h_n;
    logic       up_q_h, up_q_h_n, dn_q_h, dn_q_h_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ttl_74165_sync #(.WIDTH(8), .SYNC_STAGES(S)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .SH_LD_n (sh_ld_n),
        .CLK     (pclk),
        .CLK_INH (inh),
        .SER     (ser),
        .P       (p),
        .Q_H     (q_h),
        .Q_H_n   (q_h_n)
    );

    ttl_74165_sync #(.WIDTH(8), .SYNC_STAGES(S)) u_up (
        .clk     (clk),
        .reset   (reset),
        .SH_LD_n (sh_ld_n),
        .CLK     (pclk),
        .CLK_INH (inh),
        .SER     (ser),
        .P       (p_up),
        .Q_H     (up_q_h),
        .Q_H_n   (up_q_h_n)
    );

    ttl_74165_sync #(.WIDTH(8), .SYNC_STAGES(S)) u_dn (
        .clk     (clk),
        .reset   (reset),
        .SH_LD_n (sh_ld_n),
        .CLK     (pclk),
        .CLK_INH (inh),
        .SER     (up_q_h),
        .P       (p_dn),
        .Q_H     (dn_q_h),
        .Q_H_n   (dn_q_h_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: the chip sees each pin S cycles late; it loads while SH_LD_n is low and shifts
    // on each rising edge of (CLK | CLK_INH).
    typedef struct packed {
        logic       ld;
        logic       ck;
        logic       inh;
        logic       ser;
        logic [7:0] p;
    } pins_t;

    pins_t      hist[$];
    logic [7:0] m_sr;
    bit         m_gprev;

    task automatic model_reset();
        pins_t rp;
        rp = '{ld: 1'b1, ck: 1'b1, inh: 1'b1, ser: 1'b0, p: 8'h00};
        hist.delete();
        for (int i = 0; i < S; i++) hist.push_back(rp);
        m_sr    = 8'h00;
        m_gprev = 1'b1;
    endtask

    task automatic tick();
        pins_t cur, eff;
        bit    g, rise, exp_q, exp_qn;
        cur = '{ld: sh_ld_n, ck: pclk, inh: inh, ser: ser, p: p};
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (S == 0) begin
                eff = cur;
            end else begin
                eff = hist.pop_front();
                hist.push_back(cur);
            end
            g       = eff.ck | eff.inh;
            rise    = g && !m_gprev;
            m_gprev = g;
            if (!eff.ld) m_sr = eff.p;
            else if (rise) m_sr = {m_sr[6:0], eff.ser};
        end
        #1;
        exp_q  = m_sr[7];
        exp_qn = !m_sr[7];
        check("model_qh", {31'b0, q_h}, {31'b0, exp_q});
        check("model_qhn", {31'b0, q_h_n}, {31'b0, exp_qn});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [7:0] v);
        p       = v;
        sh_ld_n = 1'b0;
        ticks(4);
        sh_ld_n = 1'b1;
        ticks(3);
    endtask

    task automatic pulse_clk();
        pclk = 1'b1;
        ticks(3);
        pclk = 1'b0;
        ticks(3);
    endtask

    initial begin
        logic [15:0] chain_word;
        logic [7:0]  a5;
        a5    = 8'hA5;
        reset = 1'b1;
        sh_ld_n = 1'b1;
        pclk  = 1'b1;
        inh   = 1'b0;
        ser   = 1'b0;
        p     = 8'h00;
        p_up  = 8'h00;
        p_dn  = 8'h00;
        model_reset();

        // 1: release reset with CLK held high; nothing may shift.
        ticks(3);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t1_qh", {31'b0, q_h}, 32'd0);
            check("t1_qhn", {31'b0, q_h_n}, 32'd1);
        end
        pclk = 1'b0;
        ticks(3);

        // 2: load 0xA5 and shift out MSB first, with latency check on the first rise.
        load(a5);
        check("t2_load", {31'b0, q_h}, 32'd1);
        pclk = 1'b1;
        ticks(2);
        check("t2_lat_early", {31'b0, q_h}, 32'd1);
        tick();
        check("t2_lat", {31'b0, q_h}, 32'd0);
        pclk = 1'b0;
        ticks(3);
        for (int k = 2; k <= 8; k++) begin
            pulse_clk();
            check($sformatf("t2_bit%0d", k), {31'b0, q_h}, (k < 8) ? {31'b0, a5[7-k]} : 32'd0);
        end

        // 3: CLK_INH high blocks shifting; dropping it while CLK is high is not an edge.
        load(8'hFF);
        inh = 1'b1;
        ticks(3);
        for (int i = 0; i < 5; i++) pulse_clk();
        check("t3_inh", {31'b0, q_h}, 32'd1);
        pclk = 1'b1;
        ticks(3);
        inh = 1'b0;
        ticks(4);
        check("t3_drop", {31'b0, q_h}, 32'd1);
        pclk = 1'b0;
        ticks(3);

        // 4: load and rise in the same cycle -> load wins, no extra shift afterwards.
        p       = 8'h01;
        sh_ld_n = 1'b0;
        pclk    = 1'b1;
        ticks(4);
        sh_ld_n = 1'b1;
        ticks(4);
        check("t4_qh", {31'b0, q_h}, 32'd0);
        pclk = 1'b0;
        ticks(3);
        for (int k = 1; k <= 7; k++) begin
            pulse_clk();
            check($sformatf("t4_shift%0d", k), {31'b0, q_h}, (k == 7) ? 32'd1 : 32'd0);
        end

        // 5: reset mid-shift discards data; the first rise afterwards shifts SER normally.
        load(8'h80);
        for (int k = 0; k < 3; k++) pulse_clk();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst", {31'b0, q_h}, 32'd0);
        ticks(3);
        ser = 1'b1;
        pulse_clk();
        ser = 1'b0;
        for (int k = 2; k <= 8; k++) pulse_clk();
        check("t5_ser", {31'b0, q_h}, 32'd1);

        // 6: cascade two chips; downstream emits 0x34 then 0x12, MSB first.
        p_up = 8'h12;
        p_dn = 8'h34;
        chain_word = 16'h3412;
        load(8'h00);
        check("t6_k0", {31'b0, dn_q_h}, {31'b0, chain_word[15]});
        for (int k = 1; k < 16; k++) begin
            pulse_clk();
            check($sformatf("t6_k%0d", k), {31'b0, dn_q_h}, {31'b0, chain_word[15-k]});
        end
        check("t6_up_qhn", {31'b0, up_q_h_n}, {31'b0, ~up_q_h});
        check("t6_dn_qhn", {31'b0, dn_q_h_n}, {31'b0, ~dn_q_h});

        // Random pin activity, each value held at least two cycles.
        for (int i = 0; i < 400; i++) begin
            pclk    = 1'($urandom_range(0, 1));
            inh     = ($urandom_range(0, 3) == 0);
            sh_ld_n = ($urandom_range(0, 6) != 0);
            ser     = 1'($urandom_range(0, 1));
            p       = 8'($urandom());
            reset   = ($urandom_range(0, 49) == 0);
            ticks(2);
            reset   = 1'b0;
        end
        ticks(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
